p_mul_iter: RTL and testbench
=============================

// Module: p_mul_iter
//
// PURPOSE
//  Iterative packed multiplier: one shift-and-add step per cycle, all lanes in
//    parallel, for pack widths 32/16/8/4/2 (same one-hot pw encoding as p_addsub).
//  Full 2w-bit lane products, plain or carry-less (GF(2)).
//  Sits beside p_addsub in the packed-arithmetic datapath; accumulation runs on a
//    lane-isolated add, so carries never cross a lane boundary.
//
// PARAMETERS
//  (none) - datapath fixed at 32-bit operands, 64-bit result.
//
// PORTS
//  clock      in   1   system clock, all state updates on rising edge
//  reset      in   1   synchronous, active-high reset
//  valid      in   1   request; held high with stable inputs until ready
//  crs1       in   32  multiplicand, packed lanes
//  crs2       in   32  multiplier, packed lanes
//  pw         in   5   one-hot pack width: [0]=32 [1]=16 [2]=8 [3]=4 [4]=2
//  carryless  in   1   1: XOR accumulation (clmul); 0: integer multiply
//  ready      out  1   result valid; high for exactly one cycle
//  result     out  64  [31:0] low w bits of each lane product; [63:32] high w bits
//
// BEHAVIOUR
//  - Reset: ready=0, result=0, FSM=IDLE, counter=0, accumulator=0.
//  - FSM:
//      IDLE -> RUN   when valid=1. Latch crs1/crs2/pw/carryless; acc=0; cnt=0.
//      RUN  -> RUN   while cnt < w-1: for every lane with mult[cnt]=1,
//                    acc_lane += mcand_lane << cnt (2w-bit lane, carries lane-local;
//                    XOR instead of add when carryless); then cnt++.
//      RUN  -> DONE  after the step with cnt = w-1.
//      DONE -> IDLE  unconditionally. ready=1 in DONE only.
//  - pw priority when not one-hot: lowest set bit wins (pw[0] > pw[1] > ...).
//    pw=0: IDLE -> DONE directly; result=0.
//  - Latency: valid sampled high in IDLE at cycle T -> ready=1 at cycle T+w+1
//    (w=32/16/8/4/2).
//  - result: registered. Updated only on entry to DONE. Held stable until the next
//    DONE or reset.
//  - Abort: valid=0 in any RUN cycle -> IDLE next cycle. ready not asserted. result
//    unchanged.
//  - Back-to-back: requester drops valid or changes operands in the cycle after
//    ready. IDLE re-samples valid that cycle, so a new op may start one cycle after
//    ready.
//  - Inputs changed while valid=1 in RUN are ignored; the latched copies are used.
//  - Reset asserted mid-operation: all state returns to reset values next edge.
//    No ready is produced for the killed op.
//  - Integer mode is unsigned: lane product = mcand_lane * mult_lane mod 2^(2w).
//    Never overflows.
//
// TESTING
//  1. pw=00001, crs1=crs2=0xFFFFFFFF, carryless=0 -> ready at T+33,
//     result=0xFFFFFFFE_00000001.
//  2. pw=00100, crs1=0xFF020304, crs2=0xFF101010 -> ready at T+9,
//     result=0xFE000000_01203040.
//  3. pw=00001, crs1=0x3, crs2=0x3, carryless=1 -> ready at T+33,
//     result=0x00000000_00000005.
//  4. pw=10000, crs1=crs2=0xFFFFFFFF -> ready at T+3, result=0xAAAAAAAA_55555555.
//  5. Abort: pw=00001 op, valid dropped at T+5 -> no ready, result unchanged.
//     A following pw=00010 op (crs1=0x00020003, crs2=0x00040005) -> ready at T'+17,
//     result=0x00000000_0008000F.
//  6. reset pulsed at T+4 of a pw=00001 op -> ready=0, result=0 next cycle.
//     Test 1 rerun afterwards passes.
//  Bench also compares against a per-lane reference model on random inputs,
//  all pw and carryless values.

Source files
------------

// File: rtl/p_mul_iter_if.sv
// Request/response bundle for the iterative packed multiplier.
// The requester drives the operands and holds valid until ready pulses.
interface p_mul_iter_if;
  logic        valid;
  logic [31:0] crs1;
  logic [31:0] crs2;
  logic [4:0]  pw;
  logic        carryless;
  logic        ready;
  logic [63:0] result;

  modport master (
    output valid, crs1, crs2, pw, carryless,
    input  ready, result
  );

  modport slave (
    input  valid, crs1, crs2, pw, carryless,
    output ready, result
  );
endinterface

// File: rtl/p_mul_iter.sv
// Iterative packed multiplier.
// Each RUN cycle performs one shift-and-add step in every lane at once.
// The accumulator holds each lane product in a contiguous 2w-bit slot
// (lane k at bits [k*2w +: 2w]). Each slot gets its own adder, so carries
// never leave a lane.
// On the final step the slots are unpacked into the result register:
// the low halves go to [31:0] and the high halves to [63:32].
module p_mul_iter (
  input  logic        clock,
  input  logic        reset,
  p_mul_iter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] SEL_NONE = 3'd7;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] result_q, result_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mult_q, mult_d;
  logic [2:0]  sel_q, sel_d;
  logic        cl_q, cl_d;

  logic [63:0] stepAcc [5];
  logic [63:0] stepRes [5];
  logic [63:0] selAcc;
  logic [63:0] selRes;
  logic [4:0]  lastCnt;

  // Lowest set pw bit selects the lane width; no bit set means "no work".
  function automatic logic [2:0] selOf(input logic [4:0] pw);
    if (pw[0])      return 3'd0;
    else if (pw[1]) return 3'd1;
    else if (pw[2]) return 3'd2;
    else if (pw[3]) return 3'd3;
    else if (pw[4]) return 3'd4;
    else            return SEL_NONE;
  endfunction

  // One step datapath per lane width; the latched width picks which one counts.
  for (genvar g = 0; g < 5; g++) begin : gWidth
    localparam int W = 32 >> g;
    localparam int N = 32 / W;
    logic [63:0] accW;
    logic [63:0] resW;
    logic [$clog2(W)-1:0] cntLocal;

    assign cntLocal = cnt_q[$clog2(W)-1:0];

    for (genvar k = 0; k < N; k++) begin : gLane
      logic [4:0]     idx;
      logic           multBit;
      logic [2*W-1:0] addend;
      logic [2*W-1:0] seg;

      assign idx     = 5'(k * W) + 5'(cntLocal);
      assign multBit = mult_q[idx];
      assign addend  = multBit ? ((2*W)'(mcand_q[k*W +: W]) << cntLocal) : '0;
      assign seg     = acc_q[k*2*W +: 2*W];
      assign accW[k*2*W +: 2*W] = cl_q ? (seg ^ addend) : (seg + addend);
      assign resW[k*W +: W]      = accW[k*2*W +: W];
      assign resW[32 + k*W +: W] = accW[k*2*W + W +: W];
    end

    assign stepAcc[g] = accW;
    assign stepRes[g] = resW;
  end

  // Select the active width's step outputs and its final counter value.
  always_comb begin
    selAcc  = stepAcc[0];
    selRes  = stepRes[0];
    lastCnt = 5'd31;
    case (sel_q)
      3'd1: begin selAcc = stepAcc[1]; selRes = stepRes[1]; lastCnt = 5'd15; end
      3'd2: begin selAcc = stepAcc[2]; selRes = stepRes[2]; lastCnt = 5'd7;  end
      3'd3: begin selAcc = stepAcc[3]; selRes = stepRes[3]; lastCnt = 5'd3;  end
      3'd4: begin selAcc = stepAcc[4]; selRes = stepRes[4]; lastCnt = 5'd1;  end
      default: ;
    endcase
  end

  // Sequencing: latch in IDLE, step in RUN (abort on valid low), pulse in DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    mcand_d  = mcand_q;
    mult_d   = mult_q;
    sel_d    = sel_q;
    cl_d     = cl_q;
    case (state_q)
      IDLE: begin
        if (bus.valid) begin
          mcand_d = bus.crs1;
          mult_d  = bus.crs2;
          sel_d   = selOf(bus.pw);
          cl_d    = bus.carryless;
          acc_d   = '0;
          cnt_d   = '0;
          if (selOf(bus.pw) == SEL_NONE) begin
            state_d  = DONE;
            result_d = '0;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (!bus.valid) begin
          state_d = IDLE;
        end else begin
          acc_d = selAcc;
          if (cnt_q == lastCnt) begin
            state_d  = DONE;
            result_d = selRes;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      mcand_q  <= '0;
      mult_q   <= '0;
      sel_q    <= '0;
      cl_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      mcand_q  <= mcand_d;
      mult_q   <= mult_d;
      sel_q    <= sel_d;
      cl_q     <= cl_d;
    end
  end

  assign bus.ready  = (state_q == DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_p_mul_iter.sv
// Bench for the iterative packed multiplier.
// Expected results and latencies are queued when an operation is launched
// and compared when ready appears.
module tb_p_mul_iter;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  logic [63:0] expQ[$];
  int          latQ[$];
  logic [63:0] lastResult;

  p_mul_iter_if bus ();

  p_mul_iter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Lane width chosen by the lowest set pw bit, 0 if none.
  function automatic int widthOf(input logic [4:0] pw);
    if (pw[0]) return 32;
    if (pw[1]) return 16;
    if (pw[2]) return 8;
    if (pw[3]) return 4;
    if (pw[4]) return 2;
    return 0;
  endfunction

  // Reference: per-lane product (integer multiply or carry-less), then unpacked.
  function automatic logic [63:0] model(input logic [4:0] pw, input logic [31:0] a,
                                       input logic [31:0] b, input logic cl);
    logic [63:0] res;
    logic [63:0] mask;
    logic [63:0] al;
    logic [63:0] bl;
    logic [63:0] p;
    int w;
    res = '0;
    w = widthOf(pw);
    if (w == 0) return res;
    mask = (64'd1 << w) - 64'd1;
    for (int k = 0; k < 32 / w; k++) begin
      al = (64'(a) >> (k * w)) & mask;
      bl = (64'(b) >> (k * w)) & mask;
      if (cl) begin
        p = '0;
        for (int j = 0; j < w; j++) if (bl[j]) p = p ^ (al << j);
      end else begin
        p = al * bl;
      end
      for (int i = 0; i < w; i++) begin
        res[k * w + i]      = p[i];
        res[32 + k * w + i] = p[w + i];
      end
    end
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Launch one operation (called at a negedge with the DUT idle) and wait for ready.
  task automatic applyStimulus(input string tag, input logic [4:0] pw, input logic [31:0] a,
                               input logic [31:0] b, input logic cl, input bit scramble);
    int cycles;
    bit seen;
    logic [63:0] expR;
    int expL;
    expQ.push_back(model(pw, a, b, cl));
    latQ.push_back(widthOf(pw) + 1);
    bus.valid     = 1'b1;
    bus.crs1      = a;
    bus.crs2      = b;
    bus.pw        = pw;
    bus.carryless = cl;
    cycles = 0;
    seen   = 0;
    while (!seen && cycles < 60) begin
      @(negedge clock);
      cycles++;
      if (bus.ready) seen = 1;
      else if (scramble) begin
        bus.crs1      = $urandom;
        bus.crs2      = $urandom;
        bus.pw        = 5'($urandom_range(0, 31));
        bus.carryless = 1'($urandom_range(0, 1));
      end
    end
    expR = expQ.pop_front();
    expL = latQ.pop_front();
    if (!seen) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout observed=no_ready expected=ready_after_%0d", tag, expL);
    end else begin
      checkOutput({tag, "_latency"}, 64'(cycles), 64'(expL));
      checkOutput({tag, "_result"}, bus.result, expR);
    end
    lastResult = expR;
    bus.valid = 1'b0;
    @(negedge clock);
    checkOutput({tag, "_readyPulse"}, 64'(bus.ready), 64'd0);
  endtask

  initial begin
    bit sawReady;
    checks = 0;
    errors = 0;
    lastResult    = '0;
    reset         = 1'b1;
    bus.valid     = 1'b0;
    bus.crs1      = '0;
    bus.crs2      = '0;
    bus.pw        = '0;
    bus.carryless = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset_ready", 64'(bus.ready), 64'd0);
    checkOutput("reset_result", bus.result, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Directed cases with known answers.
    applyStimulus("t1_pw32", 5'b00001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
    checkOutput("t1_value", lastResult, 64'hFFFFFFFE_00000001);
    applyStimulus("t2_pw8", 5'b00100, 32'hFF020304, 32'hFF101010, 1'b0, 0);
    checkOutput("t2_value", lastResult, 64'hFE000000_01203040);
    applyStimulus("t3_clmul", 5'b00001, 32'h3, 32'h3, 1'b1, 0);
    checkOutput("t3_value", lastResult, 64'h00000000_00000005);
    applyStimulus("t4_pw2", 5'b10000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
    checkOutput("t4_value", lastResult, 64'hAAAAAAAA_55555555);
    applyStimulus("pw_zero", 5'b00000, 32'h12345678, 32'h9ABCDEF0, 1'b0, 0);
    applyStimulus("pw_prio", 5'b10110, 32'hFFFF0003, 32'h00020005, 1'b0, 0);

    // Abort: valid dropped mid-run, nothing produced, result held.
    bus.valid = 1'b1;
    bus.crs1  = 32'hDEADBEEF;
    bus.crs2  = 32'h12345678;
    bus.pw    = 5'b00001;
    bus.carryless = 1'b0;
    repeat (5) @(negedge clock);
    bus.valid = 1'b0;
    sawReady = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus.ready) sawReady = 1;
    end
    checkOutput("abort_noReady", 64'(sawReady), 64'd0);
    checkOutput("abort_resultHeld", bus.result, lastResult);
    applyStimulus("t5_pw16", 5'b00010, 32'h00020003, 32'h00040005, 1'b0, 0);
    checkOutput("t5_value", lastResult, 64'h00000000_0008000F);

    // Reset in the middle of an operation.
    bus.valid = 1'b1;
    bus.crs1  = 32'hFFFFFFFF;
    bus.crs2  = 32'hFFFFFFFF;
    bus.pw    = 5'b00001;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midReset_ready", 64'(bus.ready), 64'd0);
    checkOutput("midReset_result", bus.result, 64'd0);
    reset = 1'b0;
    bus.valid = 1'b0;
    lastResult = '0;
    sawReady = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus.ready) sawReady = 1;
    end
    checkOutput("midReset_noReady", 64'(sawReady), 64'd0);
    applyStimulus("t6_rerun", 5'b00001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
    checkOutput("t6_value", lastResult, 64'hFFFFFFFE_00000001);

    // Random operands over every width and both modes, inputs scrambled mid-run.
    for (int i = 0; i < 20; i++) begin
      applyStimulus("rand_onehot", 5'(1 << (i % 5)), $urandom, $urandom, 1'((i / 5) % 2), 1);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus("rand_pw", 5'($urandom_range(0, 31)), $urandom, $urandom,
                    1'($urandom_range(0, 1)), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
